// File: rtl/wb_defs.sv
// Shared Wishbone definitions for the burst SRAM: cycle type identifiers
// and the FSM state encoding.
package wb_defs;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ACK  = 2'd2;

endpackage

// File: rtl/wb_sram_array.sv
// 32-bit word array with byte-lane write enables, one registered read port
// and one write port. Storage holds each word XORed with its preload image,
// so an all-zero power-up state reads back as the preload pattern (word
// holds its own byte address) without needing any initialisation sequence.
module wb_sram_array #(
    parameter int ADDR_WIDTH   = 10,
    parameter int FILL_PATTERN = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_adr_i,
    output logic [31:0]           rd_dat_o,
    input  logic                  wr_en_i,
    input  logic [3:0]            wr_sel_i,
    input  logic [ADDR_WIDTH-1:0] wr_adr_i,
    input  logic [31:0]           wr_dat_i
);
    localparam int          DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [31:0] PAT_MASK = (FILL_PATTERN != 0) ? '1 : '0;

    logic [31:0] mem_q [DEPTH] = '{default: '0};
    logic [31:0] rd_dat_q;
    logic [31:0] rd_pat;
    logic [31:0] wr_pat;

    assign rd_pat   = 32'({rd_adr_i, 2'b00}) & PAT_MASK;
    assign wr_pat   = 32'({wr_adr_i, 2'b00}) & PAT_MASK;
    assign rd_dat_o = rd_dat_q;

    // Byte-lane write; unselected lanes keep their stored value.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel_i[b])
                    mem_q[wr_adr_i][8*b +: 8] <= wr_dat_i[8*b +: 8] ^ wr_pat[8*b +: 8];
            end
        end
    end

    // Registered read; output holds between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rd_dat_q <= '0;
        else if (rd_en_i)
            rd_dat_q <= mem_q[rd_adr_i] ^ rd_pat;
    end

endmodule

// File: rtl/wb_burst_sram.sv
// Wishbone B3 slave memory serving classic cycles and linear incrementing
// bursts, with a programmable number of wait states before every ack beat.
//
//  state | meaning
//  IDLE  | no cycle in progress; a strobe latches the burst start address
//  WAIT  | counting wait states, ack low
//  ACK   | ack high for exactly one beat
module wb_burst_sram #(
    parameter int ADDR_WIDTH   = 10,
    parameter int WAIT_STATES  = 0,
    parameter int FILL_PATTERN = 0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [2:0]  cti_i,
    output logic        ack_o
);
    import wb_defs::*;

    localparam logic                  HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [2:0]            WAIT_LOAD = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [ADDR_WIDTH-1:0] ADR_ONE   = 1;

    state_t                  state_q, state_d;
    logic [2:0]              wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   burst_adr_q, burst_adr_d;
    logic                    req;
    logic                    unused_adr;

    assign req        = cyc_i & stb_i;
    assign ack_o      = (state_q == ST_ACK);
    assign unused_adr = ^{adr_i[31:ADDR_WIDTH+2], adr_i[1:0]};

    // Next-state, wait counter and beat address. The address a beat will
    // use is burst_adr_d, which also drives the read port so dat_o is
    // loaded on the edge that enters ACK.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_adr_d = burst_adr_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    burst_adr_d = adr_i[ADDR_WIDTH+1:2];
                    if (HAS_WAIT) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!req)
                    state_d = ST_IDLE;
                else if (wait_cnt_q == 3'd0)
                    state_d = ST_ACK;
                else
                    wait_cnt_d = wait_cnt_q - 3'd1;
            end
            ST_ACK: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    case (cti_i)
                        CTI_INCR: begin
                            burst_adr_d = burst_adr_q + ADR_ONE;
                            if (HAS_WAIT) begin
                                state_d    = ST_WAIT;
                                wait_cnt_d = WAIT_LOAD;
                            end else begin
                                state_d = ST_ACK;
                            end
                        end
                        CTI_CLASSIC, CTI_END: state_d = ST_IDLE;
                        default:              state_d = ST_IDLE;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset drops ack immediately mid-burst.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 3'd0;
            burst_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_adr_q <= burst_adr_d;
        end
    end

    wb_sram_array #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .FILL_PATTERN (FILL_PATTERN)
    ) u_array (
        .clk_i    (clock_i),
        .rst_i    (reset_i),
        .rd_en_i  (state_d == ST_ACK),
        .rd_adr_i (burst_adr_d),
        .rd_dat_o (dat_o),
        .wr_en_i  (ack_o & stb_i & we_i),
        .wr_sel_i (sel_i),
        .wr_adr_i (burst_adr_q),
        .wr_dat_i (dat_i)
    );

endmodule

// File: tb/tb_wb_burst_sram.sv
// Directed bench for wb_burst_sram: one instance with no wait states, one
// with a single wait state, both preloaded with the address pattern.
module tb_wb_burst_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic        cyc0, stb0, cyc1, stb1;
    logic [31:0] dat0, dat1;
    logic        ack0, ack1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_burst_sram #(.ADDR_WIDTH(10), .WAIT_STATES(0), .FILL_PATTERN(1)) dut0 (
        .clock_i (clk), .reset_i (rst), .adr_i (adr), .dat_i (wdat), .dat_o (dat0),
        .sel_i (sel), .we_i (we), .stb_i (stb0), .cyc_i (cyc0), .cti_i (cti), .ack_o (ack0)
    );

    wb_burst_sram #(.ADDR_WIDTH(10), .WAIT_STATES(1), .FILL_PATTERN(1)) dut1 (
        .clock_i (clk), .reset_i (rst), .adr_i (adr), .dat_i (wdat), .dat_o (dat1),
        .sel_i (sel), .we_i (we), .stb_i (stb1), .cyc_i (cyc1), .cti_i (cti), .ack_o (ack1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int which, input logic v);
        if (which == 1) begin
            cyc1 = v; stb1 = v;
        end else begin
            cyc0 = v; stb0 = v;
        end
    endtask

    // Runs a cycle until n_stop acks have been seen, checking ack timing
    // ((beat+1)*(wait+1) cycles after the request) and read data.
    // Leaves the bus asserted so callers can end or abort the cycle.
    task automatic run_beats(input int which, input logic [31:0] base, input logic wr,
                             input logic [3:0] sel_v, input logic [31:0] wbase,
                             input int n_total, input int n_stop, input logic [2:0] last_cti,
                             input logic [31:0] exp_base, input string tag);
        int          b;
        int          cycles;
        int          ws;
        logic        a;
        logic [31:0] d;
        ws   = (which == 1) ? 1 : 0;
        adr  = base;
        wdat = wbase;
        sel  = sel_v;
        we   = wr;
        cti  = (n_total == 1) ? last_cti : 3'b010;
        set_req(which, 1'b1);
        b      = 0;
        cycles = 0;
        while (b < n_stop && cycles < 64) begin
            tick();
            cycles++;
            a = (which == 1) ? ack1 : ack0;
            d = (which == 1) ? dat1 : dat0;
            if (a) begin
                chk({tag, "_lat"}, 32'(cycles), 32'((b + 1) * (ws + 1)));
                if (!wr)
                    chk({tag, "_dat"}, d, exp_base + 32'(4 * b));
                adr  = base + 32'(4 * b);
                wdat = wbase + 32'(4 * b);
                cti  = (b == n_total - 1) ? last_cti : 3'b010;
                b++;
            end
        end
        chk({tag, "_beats"}, 32'(b), 32'(n_stop));
    endtask

    task automatic end_cycle(input int which, input string tag);
        tick();
        chk({tag, "_end"}, {31'd0, (which == 1) ? ack1 : ack0}, 32'd0);
        set_req(which, 1'b0);
        we  = 1'b0;
        cti = 3'b000;
    endtask

    task automatic single(input logic [31:0] a, input logic wr, input logic [3:0] s,
                          input logic [31:0] wd, input logic [31:0] exp, input string tag);
        run_beats(0, a, wr, s, wd, 1, 1, 3'b000, exp, tag);
        end_cycle(0, tag);
    endtask

    initial begin
        rst = 1'b1;
        adr = '0; wdat = '0; sel = '0; we = 1'b0; cti = '0;
        cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
        tick();
        tick();
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_dat0", dat0, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_dat1", dat1, 32'd0);
        rst = 1'b0;
        tick();

        // 8-beat read burst, no wait states: consecutive acks, preload data
        run_beats(0, 32'h20, 1'b0, 4'hF, 32'h0, 8, 8, 3'b111, 32'h20, "t1");
        end_cycle(0, "t1");

        // One wait state: acks every other cycle; 0x8020 aliases to word 8
        run_beats(1, 32'h8020, 1'b0, 4'hF, 32'h0, 8, 8, 3'b111, 32'h20, "t2");
        end_cycle(1, "t2");

        // Write burst then read it back
        run_beats(0, 32'h40, 1'b1, 4'hF, 32'h5A00_0040, 8, 8, 3'b111, 32'h0, "t3w");
        end_cycle(0, "t3w");
        run_beats(0, 32'h40, 1'b0, 4'hF, 32'h0, 8, 8, 3'b111, 32'h5A00_0040, "t3r");
        end_cycle(0, "t3r");

        // Classic byte-lane writes
        single(32'h40, 1'b1, 4'b1111, 32'hAABB_CCDD, 32'h0, "t4w0");
        single(32'h40, 1'b1, 4'b0001, 32'h0000_0099, 32'h0, "t4w1");
        single(32'h40, 1'b1, 4'b0010, 32'h0000_8800, 32'h0, "t4w2");
        single(32'h40, 1'b1, 4'b0100, 32'h0077_0000, 32'h0, "t4w3");
        single(32'h40, 1'b1, 4'b1000, 32'h6600_0000, 32'h0, "t4w4");
        single(32'h40, 1'b0, 4'hF, 32'h0, 32'h6677_8899, "t4r");
        single(32'h44, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0, "t4w5");
        single(32'h44, 1'b0, 4'hF, 32'h0, 32'h5A00_0044, "t4r1");

        // Abort: drop cyc after the 3rd beat completes
        run_beats(0, 32'h80, 1'b0, 4'hF, 32'h0, 8, 4, 3'b111, 32'h80, "t5");
        cyc0 = 1'b0;
        tick();
        chk("t5_abort_ack", {31'd0, ack0}, 32'd0);
        stb0 = 1'b0;
        tick();
        chk("t5_idle_ack", {31'd0, ack0}, 32'd0);
        single(32'hC0, 1'b0, 4'hF, 32'h0, 32'hC0, "t5r");

        // Reset during the 4th beat of a write burst
        run_beats(0, 32'h100, 1'b1, 4'hF, 32'h1111_0000, 8, 4, 3'b111, 32'h0, "t6w");
        #2 rst = 1'b1;
        #1 chk("t6_async_ack", {31'd0, ack0}, 32'd0);
        set_req(0, 1'b0);
        we  = 1'b0;
        cti = 3'b000;
        tick();
        rst = 1'b0;
        chk("t6_rst_dat", dat0, 32'd0);
        tick();
        run_beats(0, 32'h100, 1'b0, 4'hF, 32'h0, 3, 3, 3'b111, 32'h1111_0000, "t6r");
        end_cycle(0, "t6r");
        single(32'h10C, 1'b0, 4'hF, 32'h0, 32'h10C, "t6r4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
